// File: rtl/sram_bridge_if.sv
// sram_bridge_if: groups the core-side request/response pins and the
// external SRAM pins of the bridge. The bridge uses the slave modport;
// the core side (or a bench standing in for the core and the SRAM) uses master.
interface sram_bridge_if;
  // core side
  logic        w_en;
  logic        r_en;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rd_valid;
  logic        busy;
  logic        ovf_err;
  // SRAM side
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;

  modport slave (
    input  w_en, r_en, addr, wdata, mem_rdata,
    output rdata, rd_valid, busy, ovf_err,
    output mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n
  );

  modport master (
    output w_en, r_en, addr, wdata, mem_rdata,
    input  rdata, rd_valid, busy, ovf_err,
    input  mem_addr, mem_wdata, mem_ce_n, mem_oe_n, mem_we_n
  );
endinterface

// File: rtl/sram_bridge.sv
// sram_bridge: posts core writes into a FIFO_DEPTH-entry FIFO and serialises
// writes and reads onto a single-port asynchronous SRAM. Every access holds
// its strobes for WAIT_STATES+1 cycles. A write entry stays at the FIFO head
// while it is being written and is popped on the last access cycle, so the
// in-flight write still occupies a slot.
// Optional feature: define SRAM_BRIDGE_RAW_BYPASS_EN to forward read data
// from matching queued writes and to let non-matching reads overtake them.
module sram_bridge #(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  sram_bridge_if.slave bus
);

  localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]       LAST_WAIT = 3'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_ACC = 2'd1,
    RD_ACC = 2'd2,
    RD_RET = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       wait_q, wait_d;

  logic [15:0]      fifo_addr_q [FIFO_DEPTH];
  logic [7:0]       fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             rd_pend_q;
  logic [15:0]      rd_pend_addr_q;
  logic [7:0]       rdata_q;
  logic             rd_valid_q;
  logic             ovf_q;

  logic [15:0]      mem_addr_q;
  logic [7:0]       mem_wdata_q;
  logic             mem_ce_n_q, mem_oe_n_q, mem_we_n_q;

  logic             full_s, last_s, decide_s, pop_s, push_s;
  logic             outstanding_s, rd_acc_s, rd_hit_s, rd_new_s, rd_req_s;
  logic             rd_go_s, wr_go_s;
  logic [CNT_W-1:0] rem_cnt_s;
  logic [PTR_W-1:0] head_idx_s;
  logic [15:0]      rd_addr_s;
  logic [7:0]       hit_data_s;

  assign full_s   = (count_q == FULL_CNT);
  assign last_s   = (wait_q == LAST_WAIT);
  // A new access may be dispatched from IDLE or straight out of the last
  // write cycle, which keeps write throughput at one per WAIT_STATES+1.
  assign decide_s = (state_q == IDLE) || ((state_q == WR_ACC) && last_s);
  assign pop_s    = (state_q == WR_ACC) && last_s;
  // Entries left after this cycle's pop, and the index of the next one.
  assign rem_cnt_s  = pop_s ? (count_q - CNT_W'(1)) : count_q;
  assign head_idx_s = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
  // Pushing into a full FIFO is fine when the head retires on the same edge.
  assign push_s   = bus.w_en && (!full_s || pop_s);

  // A read is outstanding from acceptance until its rd_valid cycle is over.
  assign outstanding_s = rd_pend_q || (state_q == RD_ACC) || (state_q == RD_RET);
  assign rd_acc_s      = bus.r_en && !outstanding_s;
  assign rd_new_s      = rd_acc_s && !rd_hit_s;
  assign rd_req_s      = rd_pend_q || rd_new_s;
  assign rd_addr_s     = rd_pend_q ? rd_pend_addr_q : bus.addr;

`ifdef SRAM_BRIDGE_RAW_BYPASS_EN
  logic [PTR_W-1:0] fwd_idx_s;
  logic             fwd_match_s;

  // A read never overtakes a matching write (that case is forwarded), so a
  // missing read may always go to the SRAM first.
  assign rd_go_s = decide_s && rd_req_s;

  // Newest-match search: oldest FIFO entry first, the same-cycle write last.
  always_comb begin
    rd_hit_s    = 1'b0;
    hit_data_s  = 8'h00;
    fwd_idx_s   = rd_ptr_q;
    fwd_match_s = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      fwd_idx_s   = rd_ptr_q + PTR_W'(i);
      fwd_match_s = (CNT_W'(i) < count_q) && (fifo_addr_q[fwd_idx_s] == bus.addr);
      rd_hit_s    = rd_hit_s | fwd_match_s;
      hit_data_s  = fwd_match_s ? fifo_data_q[fwd_idx_s] : hit_data_s;
    end
    fwd_match_s = push_s;
    rd_hit_s    = rd_hit_s | fwd_match_s;
    hit_data_s  = fwd_match_s ? bus.wdata : hit_data_s;
  end
`else
  // Reads wait until every older write has left the FIFO; a write arriving
  // with the read is older and holds it back as well.
  assign rd_go_s    = decide_s && rd_req_s && (rem_cnt_s == {CNT_W{1'b0}}) &&
                      !(rd_new_s && push_s);
  assign rd_hit_s   = 1'b0;
  assign hit_data_s = 8'h00;
`endif

  assign wr_go_s = decide_s && (rem_cnt_s != {CNT_W{1'b0}}) && !rd_go_s;

  // FSM state and wait-state counter registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      wait_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // FSM next state: reads have priority at every dispatch point.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        wait_d = 3'd0;
        if (rd_go_s) begin
          state_d = RD_ACC;
        end else if (wr_go_s) begin
          state_d = WR_ACC;
        end else begin
          state_d = IDLE;
        end
      end
      WR_ACC: begin
        if (!last_s) begin
          wait_d = wait_q + 3'd1;
        end else if (rd_go_s) begin
          state_d = RD_ACC;
          wait_d  = 3'd0;
        end else if (wr_go_s) begin
          state_d = WR_ACC;
          wait_d  = 3'd0;
        end else begin
          state_d = IDLE;
          wait_d  = 3'd0;
        end
      end
      RD_ACC: begin
        if (!last_s) begin
          wait_d = wait_q + 3'd1;
        end else begin
          state_d = RD_RET;
          wait_d  = 3'd0;
        end
      end
      RD_RET: begin
        state_d = IDLE;
        wait_d  = 3'd0;
      end
      default: begin
        state_d = IDLE;
        wait_d  = 3'd0;
      end
    endcase
  end

  // Write-posting FIFO: storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= 16'h0000;
        fifo_data_q[i] <= 8'h00;
      end
    end else begin
      if (push_s) begin
        fifo_addr_q[wr_ptr_q] <= bus.addr;
        fifo_data_q[wr_ptr_q] <= bus.wdata;
        wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Read tracking, returned data, valid strobe and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rd_pend_q      <= 1'b0;
      rd_pend_addr_q <= 16'h0000;
      rdata_q        <= 8'h00;
      rd_valid_q     <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      if (rd_go_s) begin
        rd_pend_q <= 1'b0;
      end else if (rd_new_s) begin
        rd_pend_q      <= 1'b1;
        rd_pend_addr_q <= bus.addr;
      end
      if ((state_q == RD_ACC) && last_s) begin
        rdata_q <= bus.mem_rdata;
      end else if (rd_acc_s && rd_hit_s) begin
        rdata_q <= hit_data_s;
      end
      rd_valid_q <= ((state_q == RD_ACC) && last_s) || (rd_acc_s && rd_hit_s);
      ovf_q      <= ovf_q | (bus.w_en && !push_s) | (bus.r_en && outstanding_s);
    end
  end

  // SRAM pins: strobes follow the next state so they switch only when the
  // FSM changes access; address/data are loaded at dispatch.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      mem_ce_n_q  <= 1'b1;
      mem_oe_n_q  <= 1'b1;
      mem_we_n_q  <= 1'b1;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
    end else begin
      mem_ce_n_q <= !((state_d == WR_ACC) || (state_d == RD_ACC));
      mem_oe_n_q <= !(state_d == RD_ACC);
      mem_we_n_q <= !(state_d == WR_ACC);
      if (rd_go_s) begin
        mem_addr_q <= rd_addr_s;
      end else if (wr_go_s) begin
        mem_addr_q  <= fifo_addr_q[head_idx_s];
        mem_wdata_q <= fifo_data_q[head_idx_s];
      end
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = full_s || outstanding_s;
  assign bus.ovf_err   = ovf_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_ce_n  = mem_ce_n_q;
  assign bus.mem_oe_n  = mem_oe_n_q;
  assign bus.mem_we_n  = mem_we_n_q;

endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed test of sram_bridge (WAIT_STATES=2, FIFO_DEPTH=4)
// against a behavioural asynchronous SRAM that commits a write only after a
// complete WAIT_STATES+1 cycle strobe.
module tb_sram_bridge;

  localparam int WS = 2;
`ifdef SRAM_BRIDGE_RAW_BYPASS_EN
  localparam int LAT_BEHIND = 1;
  localparam int LAT_SIMUL  = 1;
`else
  localparam int LAT_BEHIND = 11;
  localparam int LAT_SIMUL  = 8;
`endif

  logic clk;
  logic n_rst;
  sram_bridge_if bus ();

  sram_bridge #(.WAIT_STATES(WS), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  sram [0:65535];
  int          we_cycles = 0;
  int          oe_cycles = 0;
  int          conflict_cnt = 0;
  int          wr_run = 0;
  logic [15:0] last_addr = 16'h0000;

  assign bus.mem_rdata = (!bus.mem_ce_n && !bus.mem_oe_n) ? sram[bus.mem_addr] : 8'h00;

  // SRAM model: preload, then per-cycle strobe monitoring and write commit.
  initial begin
    for (int a = 0; a < 65536; a++) sram[a] = 8'h00;
    sram[16'h0300] = 8'h5C;
    sram[16'h0200] = 8'h3C;
    forever begin
      @(negedge clk);
      if (!bus.mem_we_n) we_cycles++;
      if (!bus.mem_oe_n) oe_cycles++;
      if (!bus.mem_we_n && !bus.mem_oe_n) conflict_cnt++;
      if (!bus.mem_ce_n && !bus.mem_we_n) begin
        if (wr_run != 0 && bus.mem_addr != last_addr) wr_run = 0;
        wr_run++;
        last_addr = bus.mem_addr;
        if (wr_run == WS + 1) begin
          sram[bus.mem_addr] = bus.mem_wdata;
          wr_run = 0;
        end
      end else begin
        wr_run = 0;
      end
    end
  end

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.w_en  = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick();
    bus.w_en  = 1'b0;
  endtask

  // Read request (optionally with a same-cycle write); lat counts cycles
  // from the request cycle to the rd_valid cycle, -1 if none within 60.
  task automatic rd(input logic [15:0] a, input logic with_wr, input logic [7:0] wd,
                    output int lat, output logic [7:0] d);
    bus.r_en  = 1'b1;
    bus.w_en  = with_wr;
    bus.addr  = a;
    bus.wdata = wd;
    tick();
    bus.r_en = 1'b0;
    bus.w_en = 1'b0;
    lat = -1;
    d   = 8'h00;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.rd_valid) begin
        lat = k;
        d   = bus.rdata;
        break;
      end
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int         lat;
  logic [7:0] d;
  int         we0, oe0;

  initial begin
    n_rst     = 1'b0;
    bus.w_en  = 1'b0;
    bus.r_en  = 1'b0;
    bus.addr  = 16'h0000;
    bus.wdata = 8'h00;
    repeat (2) tick();
    chk("rst_rdata", bus.rdata, 8'h00);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ovf", bus.ovf_err, 1'b0);
    chk("rst_strobes", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, 3'b111);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_mem_wdata", bus.mem_wdata, 8'h00);
    n_rst = 1'b1;
    repeat (2) tick();

    // single write then read
    we0 = we_cycles;
    wr(16'h1234, 8'hA5);
    repeat (8) tick();
    chk("single_we_len", we_cycles - we0, 3);
    chk("single_sram", sram[16'h1234], 8'hA5);
    oe0 = oe_cycles;
    rd(16'h1234, 1'b0, 8'h00, lat, d);
    chk("single_rd_lat", lat, 4);
    chk("single_rdata", d, 8'hA5);
    chk("single_oe_len", oe_cycles - oe0, 3);

    // reset in the middle of a write access
    wr(16'h0300, 8'h99);
    wr(16'h0301, 8'h77);
    chk("mid_wr_we_low", bus.mem_we_n, 1'b0);
    tick();
    n_rst = 1'b0;
    tick();
    chk("mid_rst_strobes", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, 3'b111);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_rdata", bus.rdata, 8'h00);
    chk("mid_rst_rd_valid", bus.rd_valid, 1'b0);
    chk("mid_rst_ovf", bus.ovf_err, 1'b0);
    chk("mid_rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("mid_rst_mem_wdata", bus.mem_wdata, 8'h00);
    tick();
    n_rst = 1'b1;
    repeat (6) tick();
    chk("mid_rst_sram_old", sram[16'h0300], 8'h5C);
    chk("mid_rst_fifo_drop", sram[16'h0301], 8'h00);
    rd(16'h0300, 1'b0, 8'h00, lat, d);
    chk("mid_rst_rd_lat", lat, 4);
    chk("mid_rst_rdata", d, 8'h5C);

    // read queued behind three writes
    wr(16'h0000, 8'h10);
    wr(16'h0001, 8'h11);
    wr(16'h0002, 8'h12);
    rd(16'h0002, 1'b0, 8'h00, lat, d);
    chk("behind_rd_lat", lat, LAT_BEHIND);
    chk("behind_rdata", d, 8'h12);
    repeat (12) tick();
    chk("behind_sram", sram[16'h0002], 8'h12);

    // six back-to-back writes into a four-entry FIFO
    for (int i = 0; i < 6; i++) begin
      if (i == 3) chk("ovf_busy_3q", bus.busy, 1'b0);
      if (i == 4) chk("ovf_busy_4q", bus.busy, 1'b1);
      if (i == 5) chk("ovf_err_pre", bus.ovf_err, 1'b0);
      wr(16'(i), 8'(8'h10 + i));
    end
    chk("ovf_err_set", bus.ovf_err, 1'b1);
    repeat (20) tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ovf_sram_%0d", i), sram[16'(i)], (i < 5) ? 8'(8'h10 + i) : 8'h00);
    end
    chk("ovf_busy_drained", bus.busy, 1'b0);
    chk("ovf_err_sticky", bus.ovf_err, 1'b1);

    // simultaneous write and read to the same address
    rd(16'h0042, 1'b1, 8'h7E, lat, d);
    chk("simul_rd_lat", lat, LAT_SIMUL);
    chk("simul_rdata", d, 8'h7E);
    repeat (8) tick();
    chk("simul_sram", sram[16'h0042], 8'h7E);

`ifdef SRAM_BRIDGE_RAW_BYPASS_EN
    // forwarding from queued writes and overtaking by a missing read
    wr(16'h0100, 8'h20);
    wr(16'h0100, 8'h21);
    oe0 = oe_cycles;
    rd(16'h0100, 1'b0, 8'h00, lat, d);
    chk("byp_hit_lat", lat, 1);
    chk("byp_hit_rdata", d, 8'h21);
    chk("byp_hit_no_oe", oe_cycles - oe0, 0);
    rd(16'h0200, 1'b0, 8'h00, lat, d);
    chk("byp_miss_lat", lat, 4);
    chk("byp_miss_rdata", d, 8'h3C);
    chk("byp_overtake", sram[16'h0100], 8'h20);
    repeat (10) tick();
    chk("byp_final_sram", sram[16'h0100], 8'h21);
`endif

    chk("we_oe_conflict", conflict_cnt, 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
